// File: rtl/dcache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_pkg
// Shared definitions for the data cache miss-handling controller:
//   - default widths for address, data, byte mask and miss counter
//   - default memory timeout in cycles
//   - controller state encoding
// ---------------------------------------------------------------------------
package dcache_ctrl_pkg;

   localparam int ADDR_WIDTH_DEF = 10;   // 5-bit tag + 5-bit index
   localparam int DATA_WIDTH_DEF = 32;
   localparam int MASK_WIDTH     = 4;    // one enable per byte of a word
   localparam int TIMEOUT_DEF    = 64;
   localparam int CNT_WIDTH_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE,
      WRITEBACK,
      REFILL,
      INSTALL,
      REPLAY
   } ctrl_state_t;

endpackage : dcache_ctrl_pkg

// File: rtl/mem_timeout_counter.sv
// ---------------------------------------------------------------------------
// mem_timeout_counter
// Counts cycles spent waiting on a memory transaction.
//   clk, reset : clock and synchronous active-high reset
//   load       : restart the count at zero (a new wait begins)
//   count_en   : advance the count by one (a cycle passed without mem_ready)
//   expired    : the count has reached TIMEOUT-1
// The count holds at TIMEOUT-1 so expired stays asserted until reloaded.
// ---------------------------------------------------------------------------
module mem_timeout_counter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic count_en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         count_reg <= '0;
      end else if (count_en && (count_reg != LAST)) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign expired = (count_reg == LAST);

endmodule : mem_timeout_counter

// File: rtl/data_cache_controller.sv
// ---------------------------------------------------------------------------
// data_cache_controller
// Miss sequencer between the CPU load/store stage, a 2-way data cache and
// data memory. Hits complete with no stall. A miss stalls the CPU, flushes a
// dirty LRU victim, refills the line, installs it and replays the access.
//   CPU side   : cpu_read/cpu_write/cpu_address/cpu_write_data/cpu_write_mask,
//                cpu_stall
//   Cache side : cache_hit, cache_victim_dirty, cache_flush_{address,data,mask}
//                in; cache_read_enable, cache_write_enable, cache_address,
//                cache_fill, cache_fill_data out
//   Memory     : mem_request, mem_write, mem_address, mem_write_data,
//                mem_write_mask out; mem_read_data, mem_ready in
//   Status     : miss_count (saturating), mem_error (sticky timeout/replay)
// ---------------------------------------------------------------------------
module data_cache_controller
   import dcache_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_write_data,
   input  logic [MASK_WIDTH-1:0] cpu_write_mask,
   output logic                  cpu_stall,
   input  logic                  cache_hit,
   input  logic                  cache_victim_dirty,
   input  logic [ADDR_WIDTH-1:0] cache_flush_address,
   input  logic [DATA_WIDTH-1:0] cache_flush_data,
   input  logic [MASK_WIDTH-1:0] cache_flush_mask,
   output logic                  cache_read_enable,
   output logic                  cache_write_enable,
   output logic [ADDR_WIDTH-1:0] cache_address,
   output logic                  cache_fill,
   output logic [DATA_WIDTH-1:0] cache_fill_data,
   output logic                  mem_request,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic [MASK_WIDTH-1:0] mem_write_mask,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   input  logic                  mem_ready,
   output logic [CNT_WIDTH-1:0]  miss_count,
   output logic                  mem_error
);

   ctrl_state_t           state_reg;
   logic                  op_write_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [MASK_WIDTH-1:0] wmask_reg;
   logic [DATA_WIDTH-1:0] fill_data_reg;
   logic                  cache_fill_reg;
   logic                  mem_request_reg;
   logic                  mem_write_reg;
   logic [ADDR_WIDTH-1:0] mem_address_reg;
   logic [DATA_WIDTH-1:0] mem_write_data_reg;
   logic [MASK_WIDTH-1:0] mem_write_mask_reg;
   logic [CNT_WIDTH-1:0]  miss_count_reg;
   logic                  mem_error_reg;

   logic request;
   logic miss;
   logic load_timer;
   logic count_timer;
   logic timer_expired;

   assign request = cpu_read | cpu_write;
   assign miss    = (state_reg == IDLE) && request && !cache_hit;

   // A wait starts when a miss launches the first memory transaction, and
   // again when the writeback completes and the refill read begins.
   assign load_timer  = miss || ((state_reg == WRITEBACK) && mem_ready);
   assign count_timer = ((state_reg == WRITEBACK) || (state_reg == REFILL)) && !mem_ready;

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .load     (load_timer),
      .count_en (count_timer),
      .expired  (timer_expired)
   );

   // The memory-side outputs double as the victim latches: the flush fields
   // are captured straight into them on a dirty miss.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= IDLE;
         op_write_reg       <= 1'b0;
         addr_reg           <= '0;
         wdata_reg          <= '0;
         wmask_reg          <= '0;
         fill_data_reg      <= '0;
         cache_fill_reg     <= 1'b0;
         mem_request_reg    <= 1'b0;
         mem_write_reg      <= 1'b0;
         mem_address_reg    <= '0;
         mem_write_data_reg <= '0;
         mem_write_mask_reg <= '0;
         miss_count_reg     <= '0;
         mem_error_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (miss) begin
                  op_write_reg    <= cpu_write;
                  addr_reg        <= cpu_address;
                  wdata_reg       <= cpu_write_data;
                  wmask_reg       <= cpu_write_mask;
                  mem_request_reg <= 1'b1;
                  if (miss_count_reg != '1) begin
                     miss_count_reg <= miss_count_reg + CNT_WIDTH'(1);
                  end
                  if (cache_victim_dirty) begin
                     mem_write_reg      <= 1'b1;
                     mem_address_reg    <= cache_flush_address;
                     mem_write_data_reg <= cache_flush_data;
                     mem_write_mask_reg <= cache_flush_mask;
                     state_reg          <= WRITEBACK;
                  end else begin
                     mem_write_reg   <= 1'b0;
                     mem_address_reg <= cpu_address;
                     state_reg       <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  mem_write_reg   <= 1'b0;
                  mem_address_reg <= addr_reg;
                  state_reg       <= REFILL;
               end else if (timer_expired) begin
                  mem_error_reg   <= 1'b1;
                  mem_request_reg <= 1'b0;
                  mem_write_reg   <= 1'b0;
                  state_reg       <= IDLE;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  fill_data_reg   <= mem_read_data;
                  mem_request_reg <= 1'b0;
                  cache_fill_reg  <= 1'b1;
                  state_reg       <= INSTALL;
               end else if (timer_expired) begin
                  mem_error_reg   <= 1'b1;
                  mem_request_reg <= 1'b0;
                  state_reg       <= IDLE;
               end
            end
            INSTALL: begin
               cache_fill_reg <= 1'b0;
               state_reg      <= REPLAY;
            end
            REPLAY: begin
               // The line was just installed, so a replay miss means the
               // cache and controller disagree; flag it and let the CPU retry.
               if (!cache_hit) begin
                  mem_error_reg <= 1'b1;
               end
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      cache_address      = addr_reg;
      cache_read_enable  = 1'b0;
      cache_write_enable = 1'b0;
      cpu_stall          = 1'b0;
      cache_fill_data    = fill_data_reg;
      case (state_reg)
         IDLE: begin
            cache_address      = cpu_address;
            cache_read_enable  = cpu_read & ~cpu_write;   // write wins
            cache_write_enable = cpu_write;
            cpu_stall          = request & ~cache_hit;
         end
         WRITEBACK, REFILL, INSTALL: begin
            cpu_stall = 1'b1;
         end
         REPLAY: begin
            // The cache data port is shared: a replayed store presents its
            // latched data there. A store with no byte enables writes nothing.
            cache_read_enable  = ~op_write_reg;
            cache_write_enable = op_write_reg & (|wmask_reg);
            cpu_stall          = ~cache_hit;
            if (op_write_reg) begin
               cache_fill_data = wdata_reg;
            end
         end
         default: begin
            cpu_stall = 1'b0;
         end
      endcase
   end

   assign cache_fill     = cache_fill_reg;
   assign mem_request    = mem_request_reg;
   assign mem_write      = mem_write_reg;
   assign mem_address    = mem_address_reg;
   assign mem_write_data = mem_write_data_reg;
   assign mem_write_mask = mem_write_mask_reg;
   assign miss_count     = miss_count_reg;
   assign mem_error      = mem_error_reg;

endmodule : data_cache_controller

// File: tb/tb_data_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_data_cache_controller
// Directed test of the data cache miss sequencer with hand-computed
// expectations. Inputs change on the falling edge; outputs are checked 1ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_data_cache_controller;

   logic        clk;
   logic        reset;
   logic        cpu_read;
   logic        cpu_write;
   logic [9:0]  cpu_address;
   logic [31:0] cpu_write_data;
   logic [3:0]  cpu_write_mask;
   logic        cpu_stall;
   logic        cache_hit;
   logic        cache_victim_dirty;
   logic [9:0]  cache_flush_address;
   logic [31:0] cache_flush_data;
   logic [3:0]  cache_flush_mask;
   logic        cache_read_enable;
   logic        cache_write_enable;
   logic [9:0]  cache_address;
   logic        cache_fill;
   logic [31:0] cache_fill_data;
   logic        mem_request;
   logic        mem_write;
   logic [9:0]  mem_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_write_mask;
   logic [31:0] mem_read_data;
   logic        mem_ready;
   logic [15:0] miss_count;
   logic        mem_error;

   int n_checks = 0;
   int n_fail   = 0;

   data_cache_controller dut (
      .clk                 (clk),
      .reset               (reset),
      .cpu_read            (cpu_read),
      .cpu_write           (cpu_write),
      .cpu_address         (cpu_address),
      .cpu_write_data      (cpu_write_data),
      .cpu_write_mask      (cpu_write_mask),
      .cpu_stall           (cpu_stall),
      .cache_hit           (cache_hit),
      .cache_victim_dirty  (cache_victim_dirty),
      .cache_flush_address (cache_flush_address),
      .cache_flush_data    (cache_flush_data),
      .cache_flush_mask    (cache_flush_mask),
      .cache_read_enable   (cache_read_enable),
      .cache_write_enable  (cache_write_enable),
      .cache_address       (cache_address),
      .cache_fill          (cache_fill),
      .cache_fill_data     (cache_fill_data),
      .mem_request         (mem_request),
      .mem_write           (mem_write),
      .mem_address         (mem_address),
      .mem_write_data      (mem_write_data),
      .mem_write_mask      (mem_write_mask),
      .mem_read_data       (mem_read_data),
      .mem_ready           (mem_ready),
      .miss_count          (miss_count),
      .mem_error           (mem_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cpu_idle();
      cpu_read       = 1'b0;
      cpu_write      = 1'b0;
      cpu_address    = '0;
      cpu_write_data = '0;
      cpu_write_mask = '0;
   endtask

   initial begin
      int req_cycles;

      reset               = 1'b1;
      cpu_idle();
      cache_hit           = 1'b0;
      cache_victim_dirty  = 1'b0;
      cache_flush_address = '0;
      cache_flush_data    = '0;
      cache_flush_mask    = '0;
      mem_read_data       = '0;
      mem_ready           = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      $display("txn reset: release");
      check("rst_stall",   32'(cpu_stall),   32'd0);
      check("rst_memreq",  32'(mem_request), 32'd0);
      check("rst_fill",    32'(cache_fill),  32'd0);
      check("rst_misscnt", 32'(miss_count),  32'd0);
      check("rst_memerr",  32'(mem_error),   32'd0);

      // ---- read hit 0x015 ----
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 10'h015; cache_hit = 1'b1;
      #1;
      $display("txn read hit 0x015");
      check("hit_stall",  32'(cpu_stall),         32'd0);
      check("hit_rden",   32'(cache_read_enable), 32'd1);
      check("hit_addr",   32'(cache_address),     32'h015);
      check("hit_memreq", 32'(mem_request),       32'd0);
      @(negedge clk);
      cpu_idle(); cache_hit = 1'b0;
      #1;
      check("hit_misscnt", 32'(miss_count),  32'd0);
      check("hit_memreq2", 32'(mem_request), 32'd0);

      // ---- clean read miss 0x035, refill after two waiting cycles ----
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 10'h035; cache_hit = 1'b0; cache_victim_dirty = 1'b0;
      #1;
      $display("txn read miss clean 0x035");
      check("cm_stall_miss", 32'(cpu_stall), 32'd1);
      @(negedge clk);               // REFILL, wait 1
      cpu_idle();
      #1;
      check("cm_memreq",  32'(mem_request), 32'd1);
      check("cm_memwr",   32'(mem_write),   32'd0);
      check("cm_memaddr", 32'(mem_address), 32'h035);
      check("cm_stall_r", 32'(cpu_stall),   32'd1);
      @(negedge clk);               // REFILL, wait 2
      #1;
      check("cm_memreq_w2", 32'(mem_request), 32'd1);
      @(negedge clk);               // REFILL, data returns
      mem_ready = 1'b1; mem_read_data = 32'hCAFEBABE;
      @(negedge clk);               // INSTALL
      mem_ready = 1'b0; mem_read_data = '0;
      #1;
      check("cm_fill",      32'(cache_fill),      32'd1);
      check("cm_filldata",  cache_fill_data,      32'hCAFEBABE);
      check("cm_filladdr",  32'(cache_address),   32'h035);
      check("cm_memreq_in", 32'(mem_request),     32'd0);
      check("cm_stall_in",  32'(cpu_stall),       32'd1);
      @(negedge clk);               // REPLAY
      cache_hit = 1'b1;
      #1;
      check("cm_rep_stall", 32'(cpu_stall),         32'd0);
      check("cm_rep_rden",  32'(cache_read_enable), 32'd1);
      check("cm_rep_addr",  32'(cache_address),     32'h035);
      check("cm_rep_fill",  32'(cache_fill),        32'd0);
      @(negedge clk);               // IDLE
      cache_hit = 1'b0;
      #1;
      check("cm_misscnt", 32'(miss_count), 32'd1);
      check("cm_memerr",  32'(mem_error),  32'd0);

      // ---- dirty write miss 0x055, mem_ready in first cycle of each phase ----
      @(negedge clk);
      cpu_write = 1'b1; cpu_address = 10'h055; cpu_write_data = 32'h19721121; cpu_write_mask = 4'b0011;
      cache_hit = 1'b0; cache_victim_dirty = 1'b1;
      cache_flush_address = 10'h015; cache_flush_data = 32'h12ADBEEF; cache_flush_mask = 4'b1111;
      #1;
      $display("txn write miss dirty 0x055 victim 0x015");
      check("dm_stall_miss", 32'(cpu_stall),          32'd1);
      check("dm_wren_idle",  32'(cache_write_enable), 32'd1);
      @(negedge clk);               // WRITEBACK
      cpu_idle(); cache_victim_dirty = 1'b0;
      cache_flush_address = '0; cache_flush_data = '0; cache_flush_mask = '0;
      mem_ready = 1'b1;
      #1;
      check("dm_wb_req",   32'(mem_request),    32'd1);
      check("dm_wb_wr",    32'(mem_write),      32'd1);
      check("dm_wb_addr",  32'(mem_address),    32'h015);
      check("dm_wb_data",  mem_write_data,      32'h12ADBEEF);
      check("dm_wb_mask",  32'(mem_write_mask), 32'hF);
      check("dm_wb_stall", 32'(cpu_stall),      32'd1);
      @(negedge clk);               // REFILL
      mem_read_data = 32'h0BADF00D;
      #1;
      check("dm_rf_req",  32'(mem_request), 32'd1);
      check("dm_rf_wr",   32'(mem_write),   32'd0);
      check("dm_rf_addr", 32'(mem_address), 32'h055);
      @(negedge clk);               // INSTALL
      mem_ready = 1'b0; mem_read_data = '0;
      #1;
      check("dm_in_fill", 32'(cache_fill), 32'd1);
      check("dm_in_data", cache_fill_data, 32'h0BADF00D);
      @(negedge clk);               // REPLAY, 4th cycle after the miss
      cache_hit = 1'b1;
      #1;
      check("dm_rep_stall", 32'(cpu_stall),          32'd0);
      check("dm_rep_wren",  32'(cache_write_enable), 32'd1);
      check("dm_rep_rden",  32'(cache_read_enable),  32'd0);
      check("dm_rep_data",  cache_fill_data,         32'h19721121);
      check("dm_rep_addr",  32'(cache_address),      32'h055);
      @(negedge clk);
      cache_hit = 1'b0;
      #1;
      check("dm_misscnt", 32'(miss_count), 32'd2);

      // ---- refill timeout on 0x077 ----
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 10'h077; cache_hit = 1'b0;
      $display("txn read miss 0x077 with no mem_ready");
      @(negedge clk);
      cpu_idle();
      req_cycles = 0;
      for (int c = 0; c < 80; c++) begin
         #1;
         if (mem_request !== 1'b1) break;
         req_cycles++;
         @(negedge clk);
      end
      check("to_req_cycles", 32'(req_cycles),  32'd64);
      check("to_memerr",     32'(mem_error),   32'd1);
      check("to_memreq",     32'(mem_request), 32'd0);
      check("to_stall",      32'(cpu_stall),   32'd0);
      check("to_misscnt",    32'(miss_count),  32'd3);

      // ---- reset during REFILL, late mem_ready ignored ----
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 10'h099; cache_hit = 1'b0;
      $display("txn read miss 0x099 then reset in REFILL");
      @(negedge clk);
      cpu_idle();
      #1;
      check("rr_memreq_pre", 32'(mem_request), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rr_memreq",  32'(mem_request), 32'd0);
      check("rr_stall",   32'(cpu_stall),   32'd0);
      check("rr_misscnt", 32'(miss_count),  32'd0);
      check("rr_memerr",  32'(mem_error),   32'd0);
      mem_ready = 1'b1; mem_read_data = 32'hDEADD00D;
      @(negedge clk);
      mem_ready = 1'b0; mem_read_data = '0;
      #1;
      check("rr_late_fill",   32'(cache_fill),  32'd0);
      check("rr_late_memreq", 32'(mem_request), 32'd0);
      check("rr_late_stall",  32'(cpu_stall),   32'd0);

      // ---- read and write together on a hit ----
      @(negedge clk);
      cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 10'h015;
      cpu_write_data = 32'h00000001; cpu_write_mask = 4'b1111; cache_hit = 1'b1;
      #1;
      $display("txn read+write hit 0x015");
      check("rw_wren",  32'(cache_write_enable), 32'd1);
      check("rw_rden",  32'(cache_read_enable),  32'd0);
      check("rw_stall", 32'(cpu_stall),          32'd0);
      @(negedge clk);
      cpu_idle(); cache_hit = 1'b0;
      #1;
      check("rw_misscnt", 32'(miss_count),  32'd0);
      check("rw_memreq",  32'(mem_request), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_data_cache_controller

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
Miss-handling sequencer between the CPU load/store stage, the 2-way DataCache and data memory. Services hits in zero extra cycles. On a miss it stalls the CPU, writes back the dirty LRU victim, refills the line from memory, installs it, then replays the original access. It also counts misses and flags memory timeouts.

Parameters:
ADDR_WIDTH, 10, word address width (5-bit tag + 5-bit index)
DATA_WIDTH, 32, word width
TIMEOUT, 64, max cycles waiting for mem_ready before error
CNT_WIDTH, 16, miss counter width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_read  input  1  load request
cpu_write  input  1  store request
cpu_address  input  ADDR_WIDTH  request address
cpu_write_data  input  DATA_WIDTH  store data
cpu_write_mask  input  4  byte enables
cpu_stall  output  1  hold the CPU pipeline
cache_hit  input  1  cache hit for the presented address
cache_victim_dirty  input  1  LRU victim at the index is dirty and must be flushed
cache_flush_address  input  ADDR_WIDTH  victim address
cache_flush_data  input  DATA_WIDTH  victim data
cache_flush_mask  input  4  victim byte mask
cache_read_enable  output  1  cache read strobe
cache_write_enable  output  1  cache write strobe
cache_address  output  ADDR_WIDTH  cache address
cache_fill  output  1  install refill word into the LRU way
cache_fill_data  output  DATA_WIDTH  refill word (the cache's dm_data)
mem_request  output  1  memory transaction valid
mem_write  output  1  1 = writeback, 0 = refill read
mem_address  output  ADDR_WIDTH  memory address
mem_write_data  output  DATA_WIDTH  writeback data
mem_write_mask  output  4  writeback mask
mem_read_data  input  DATA_WIDTH  refill data
mem_ready  input  1  transaction complete, sampled on clk
miss_count  output  CNT_WIDTH  saturating miss counter
mem_error  output  1  sticky timeout flag

Behaviour:
- Reset (sync, active-high): state=IDLE. All outputs 0, including miss_count and mem_error. A reset during any state aborts it: mem_request drops the cycle after the reset edge and any in-flight memory data is discarded.
- IDLE:
  - cache_address=cpu_address, cache_read_enable=cpu_read, cache_write_enable=cpu_write, all combinational.
  - cpu_read and cpu_write both high is treated as a write.
  - If a request is present and cache_hit=1: the access completes this cycle and cpu_stall=0.
  - If a request is present and cache_hit=0: cpu_stall=1 combinationally. Latch op, address, data and mask. Latch flush address/data/mask if cache_victim_dirty. Increment miss_count (saturates at all-ones). Next state is WRITEBACK if dirty, else REFILL.
- WRITEBACK: mem_request=1, mem_write=1, flush fields from latches. On mem_ready go to REFILL.
- REFILL: mem_request=1, mem_write=0, mem_address=latched address. On mem_ready capture mem_read_data and go to INSTALL.
- INSTALL (1 cycle): cache_fill=1, cache_fill_data=captured word, cache_address=latched address. Next state REPLAY.
- REPLAY (1 cycle): reissue the latched op with latched data/mask.
  - If cache_hit=1: cpu_stall=0 this cycle, go to IDLE.
  - If cache_hit=0: set mem_error, go to IDLE.
- cpu_stall=1 in WRITEBACK, REFILL and INSTALL.
- Stores use write-allocate.
- Miss-to-resume latency, counted in cycles after the miss cycle with mem_ready in its first cycle:
  - 3 cycles when clean (REFILL, INSTALL, REPLAY).
  - 4 cycles when dirty (adds WRITEBACK).
- Timeout:
  - A wait counter resets on entering WRITEBACK or REFILL and increments each cycle without mem_ready.
  - When it reaches TIMEOUT-1: set mem_error, drop mem_request, go to IDLE.
  - cpu_stall deasserts in IDLE, so the access retries.
- CPU inputs are ignored outside IDLE.
- mem_ready outside WRITEBACK/REFILL is ignored.

Decomposition:
- Package dcache_ctrl_pkg holds the state enum (IDLE, WRITEBACK, REFILL, INSTALL, REPLAY) and the width constants.
- One natural sub-module, mem_timeout_counter: a load/count/expire counter parameterised by TIMEOUT.

Test Plan:
- Read 0x015 with cache_hit=1 -> cpu_stall=0, no mem_request, miss_count=0.
- Read 0x035, hit=0, victim clean; mem_ready after 2 cycles with data 0xCAFEBABE -> REFILL only; INSTALL drives cache_fill with 0xCAFEBABE; REPLAY hit; miss_count=1.
- Write 0x055 data 0x19721121 mask 0011, miss with dirty victim at 0x015 data 0x12ADBEEF -> writeback to 0x015 with 0x12ADBEEF mask 1111, then refill 0x055, then replay write with mask 0011.
- Refill with mem_ready never asserted, TIMEOUT=64 -> mem_error=1 after 64 cycles, mem_request=0, state IDLE.
- Reset asserted in REFILL -> next cycle mem_request=0, cpu_stall=0, miss_count=0; a late mem_ready is ignored.
- cpu_read and cpu_write both high on a hit -> cache_write_enable=1, cache_read_enable=0.
